// File: rtl/mnist_inference_sequencer.sv
// Control sequencer for a single-layer MNIST classifier: bias preload,
// pixel MAC sweep, pipeline drain, argmax over neuron scores.
module mnist_inference_sequencer #(
    parameter int NUM_PIXELS  = 784,
    parameter int NUM_CLASSES = 10,
    parameter int ROM_LATENCY = 1,
    parameter int SCORE_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic [11:0]               pixel_addr,
    output logic [3:0]                bias_addr,
    output logic [NUM_CLASSES-1:0]    bias_load,
    output logic                      acc_clear,
    output logic                      acc_en,
    output logic [3:0]                score_sel,
    input  logic signed [SCORE_W-1:0] score_data,
    output logic [3:0]                digit,
    output logic                      digit_valid
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        BIAS,
        ACCUM,
        DRAIN,
        ARGMAX,
        DONE
    } state_t;

    localparam logic [11:0] LAST_PIX = 12'(NUM_PIXELS - 1);
    localparam logic [11:0] LAST_CLS = 12'(NUM_CLASSES - 1);
    localparam logic [11:0] LAST_DRN = 12'(ROM_LATENCY);

    state_t state;
    state_t state_next;
    logic [11:0] cnt;
    logic [11:0] cnt_next;

    logic [ROM_LATENCY-1:0] bias_vld;
    logic [ROM_LATENCY-1:0] acc_vld;
    logic [3:0]             bias_idx [ROM_LATENCY];

    logic signed [SCORE_W-1:0] best;
    logic [3:0]                best_idx;
    logic                      take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 12'd1;
        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                cnt_next   = '0;
                state_next = BIAS;
            end
            BIAS: begin
                if (cnt == LAST_CLS) begin
                    cnt_next   = '0;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (cnt == LAST_PIX) begin
                    cnt_next   = '0;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt == LAST_DRN) begin
                    cnt_next   = '0;
                    state_next = ARGMAX;
                end
            end
            ARGMAX: begin
                if (cnt == LAST_CLS) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end
            end
            DONE: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign busy        = (state != IDLE);
    assign acc_clear   = (state == CLEAR);
    assign digit_valid = (state == DONE);
    assign pixel_addr  = (state == ACCUM)  ? cnt      : '0;
    assign bias_addr   = (state == BIAS)   ? cnt[3:0] : '0;
    assign score_sel   = (state == ARGMAX) ? cnt[3:0] : '0;

    // Valid chain mirrors ROM read latency and keeps shifting across states.
    always_ff @(posedge clk) begin
        if (rst) begin
            bias_vld <= '0;
            acc_vld  <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) bias_idx[i] <= '0;
        end else begin
            bias_vld[0] <= (state == BIAS);
            acc_vld[0]  <= (state == ACCUM);
            bias_idx[0] <= cnt[3:0];
            for (int i = 1; i < ROM_LATENCY; i++) begin
                bias_vld[i] <= bias_vld[i-1];
                acc_vld[i]  <= acc_vld[i-1];
                bias_idx[i] <= bias_idx[i-1];
            end
        end
    end

    assign acc_en    = acc_vld[ROM_LATENCY-1];
    assign bias_load = bias_vld[ROM_LATENCY-1]
                     ? (NUM_CLASSES'(1) << bias_idx[ROM_LATENCY-1])
                     : '0;

    // Strict compare keeps the lowest index on ties.
    assign take = (cnt == '0) || (score_data > best);

    always_ff @(posedge clk) begin
        if (rst) begin
            best     <= '0;
            best_idx <= '0;
            digit    <= '0;
        end else if (state == ARGMAX) begin
            if (take) begin
                best     <= score_data;
                best_idx <= cnt[3:0];
            end
            if (cnt == LAST_CLS) digit <= take ? cnt[3:0] : best_idx;
        end
    end

endmodule

// File: tb/tb_mnist_inference_sequencer.sv
// Randomised bench for mnist_inference_sequencer: cycle-timeline model
// derived from phase lengths, plus a plain argmax reference.
module tb_mnist_inference_sequencer;

    localparam int P = 784;
    localparam int C = 10;

    logic clk;
    logic rst;
    logic start;

    logic        busy1, busy3;
    logic [11:0] paddr1, paddr3;
    logic [3:0]  baddr1, baddr3;
    logic [9:0]  bload1, bload3;
    logic        clr1, clr3;
    logic        acc1, acc3;
    logic [3:0]  ssel1, ssel3;
    logic signed [15:0] sd1, sd3;
    logic [3:0]  dig1, dig3;
    logic        dv1, dv3;

    logic signed [15:0] scores [C];

    bit          use3;
    logic        m_busy, m_clr, m_acc, m_dv;
    logic [11:0] m_paddr;
    logic [3:0]  m_baddr, m_ssel, m_dig;
    logic [9:0]  m_bload;

    int checks;
    int errors;
    int last_digit;

    mnist_inference_sequencer #(.ROM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy1),
        .pixel_addr(paddr1), .bias_addr(baddr1), .bias_load(bload1),
        .acc_clear(clr1), .acc_en(acc1), .score_sel(ssel1),
        .score_data(sd1), .digit(dig1), .digit_valid(dv1)
    );

    mnist_inference_sequencer #(.ROM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .busy(busy3),
        .pixel_addr(paddr3), .bias_addr(baddr3), .bias_load(bload3),
        .acc_clear(clr3), .acc_en(acc3), .score_sel(ssel3),
        .score_data(sd3), .digit(dig3), .digit_valid(dv3)
    );

    assign sd1 = (ssel1 < 4'd10) ? scores[ssel1] : 16'sd0;
    assign sd3 = (ssel3 < 4'd10) ? scores[ssel3] : 16'sd0;

    always_comb begin
        m_busy  = use3 ? busy3  : busy1;
        m_clr   = use3 ? clr3   : clr1;
        m_acc   = use3 ? acc3   : acc1;
        m_dv    = use3 ? dv3    : dv1;
        m_paddr = use3 ? paddr3 : paddr1;
        m_baddr = use3 ? baddr3 : baddr1;
        m_ssel  = use3 ? ssel3  : ssel1;
        m_dig   = use3 ? dig3   : dig1;
        m_bload = use3 ? bload3 : bload1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_argmax();
        int b = 0;
        for (int i = 1; i < C; i++)
            if (scores[i] > scores[b]) b = i;
        return b;
    endfunction

    // Enters at a negedge with the DUT idle; returns at the idle negedge
    // after DONE. With hold set, start stays high throughout.
    task automatic run_image(input int lat, input bit hold, input int pre);
        int done_n;
        int want;
        int e_busy, e_clr, e_ba, e_bl, e_pa, e_acc, e_ss, e_dv, e_dg;
        int x_busy, x_ba, x_bl, x_pa, x_ss;
        int n_acc, n_dv, dv_at, dig_at;
        done_n = 807 + lat;
        want   = ref_argmax();
        {e_busy, e_clr, e_ba, e_bl, e_pa, e_acc, e_ss, e_dv, e_dg} = '0;
        n_acc = 0; n_dv = 0; dv_at = -1; dig_at = -1;
        start = 1'b1;
        for (int n = 1; n <= done_n + 1; n++) begin
            @(negedge clk);
            if (n == 1 && !hold) start = 1'b0;
            x_busy = (n <= done_n) ? 1 : 0;
            x_ba = (n >= 2 && n <= 1 + C) ? n - 2 : 0;
            x_bl = (n >= 2 + lat && n <= 1 + C + lat) ? (1 << (n - 2 - lat)) : 0;
            x_pa = (n >= 12 && n <= 11 + P) ? n - 12 : 0;
            x_ss = (n >= done_n - C && n < done_n) ? n - (done_n - C) : 0;
            if (int'(m_busy) != x_busy) e_busy++;
            if (int'(m_clr) != ((n == 1) ? 1 : 0)) e_clr++;
            if (int'(m_baddr) != x_ba) e_ba++;
            if (int'(m_bload) != x_bl) e_bl++;
            if (int'(m_paddr) != x_pa) e_pa++;
            if (int'(m_acc) != ((n >= 12 + lat && n <= 11 + P + lat) ? 1 : 0)) e_acc++;
            if (int'(m_ssel) != x_ss) e_ss++;
            if (int'(m_dv) != ((n == done_n) ? 1 : 0)) e_dv++;
            if (n < done_n && int'(m_dig) != pre) e_dg++;
            if (m_acc) n_acc++;
            if (m_dv) begin
                n_dv++;
                if (dv_at < 0) begin
                    dv_at  = n;
                    dig_at = int'(m_dig);
                end
            end
        end
        check("busy_timeline", e_busy, 0);
        check("acc_clear_timeline", e_clr, 0);
        check("bias_addr_timeline", e_ba, 0);
        check("bias_load_timeline", e_bl, 0);
        check("pixel_addr_timeline", e_pa, 0);
        check("acc_en_timeline", e_acc, 0);
        check("score_sel_timeline", e_ss, 0);
        check("digit_valid_timeline", e_dv, 0);
        check("digit_hold_before_done", e_dg, 0);
        check("acc_en_count", n_acc, P);
        check("digit_valid_width", n_dv, 1);
        check("digit_valid_cycle", dv_at, done_n);
        check("digit_at_done", dig_at, want);
        check("digit_after_done", int'(m_dig), want);
        last_digit = want;
    endtask

    task automatic fill_random(input bit narrow);
        for (int i = 0; i < C; i++)
            scores[i] = narrow ? 16'($urandom_range(0, 6)) - 16'sd3
                               : 16'($urandom);
    endtask

    initial begin
        int found;
        int leak;
        checks = 0;
        errors = 0;
        last_digit = 0;
        use3 = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < C; i++) scores[i] = '0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("rst_beats_start", int'(m_busy), 0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(m_busy), 0);
        check("reset_outputs", int'({m_paddr, m_baddr, m_bload, m_ssel, m_dig}), 0);
        check("reset_strobes", int'({m_clr, m_acc, m_dv}), 0);

        scores = '{-16'sd5, 16'sd3, 16'sd7, 16'sd7, -16'sd100,
                   16'sd0, 16'sd2, 16'sd1, 16'sd6, -16'sd1};
        run_image(1, 1'b0, last_digit);
        check("spec_vector_digit", last_digit, 2);
        repeat ($urandom_range(0, 3)) @(negedge clk);

        for (int i = 0; i < C; i++) scores[i] = -16'sd32768;
        run_image(1, 1'b0, last_digit);
        check("all_min_digit", last_digit, 0);

        fill_random(1'b1);
        run_image(1, 1'b1, last_digit);
        fill_random(1'b0);
        run_image(1, 1'b1, last_digit);
        fill_random(1'b1);
        run_image(1, 1'b0, last_digit);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 1000 && found == 0; n++) begin
            @(negedge clk);
            if (m_busy && m_paddr == 12'd400) found = 1;
        end
        check("reach_pixel_400", found, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst_busy", int'(m_busy), 0);
        check("midrun_rst_outputs", int'({m_paddr, m_baddr, m_bload, m_ssel, m_dig}), 0);
        check("midrun_rst_strobes", int'({m_clr, m_acc, m_dv}), 0);
        leak = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_acc || m_bload != '0 || m_busy) leak++;
        end
        check("no_activity_after_rst", leak, 0);

        use3 = 1'b1;
        last_digit = 0;
        fill_random(1'b0);
        run_image(3, 1'b0, last_digit);
        fill_random(1'b1);
        run_image(3, 1'b0, last_digit);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
